program_bank_memory: RTL and testbench

//   Parametrised, loadable instruction store holding NUM_PROGRAMS banks of DEPTH words.
//   It replaces the fixed combinational program ROM, and feeds the fetch stage of the CPU.

---
 rtl/program_bank_memory.sv | 232 +++++++++++++++++++++++
 tb/tb_program_bank_memory.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_bank_memory.sv
// Loadable multi-bank instruction store with a registered fetch port, a latched
// priority-encoded program select and a valid/ready word-stream load port.
module program_bank_memory #(
    parameter int                     INSTR_WIDTH  = 16,
    parameter int                     ADDR_WIDTH   = 7,
    parameter int                     NUM_PROGRAMS = 8,
    parameter int                     PSEL_WIDTH   = 3,
    parameter logic [INSTR_WIDTH-1:0] HALT_INSTR   = 16'hE000
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    // program selection
    input  logic [NUM_PROGRAMS-1:0] i_program_select,
    input  logic                    i_select_latch,
    output logic [PSEL_WIDTH-1:0]   o_active_program,
    output logic                    o_select_none,
    // fetch port
    input  logic [ADDR_WIDTH-1:0]   i_address,
    input  logic                    i_read_en,
    output logic [INSTR_WIDTH-1:0]  o_instruction,
    output logic                    o_instr_valid,
    // load port
    input  logic                    i_load_start,
    input  logic [PSEL_WIDTH-1:0]   i_load_bank,
    input  logic                    i_load_valid,
    input  logic [INSTR_WIDTH-1:0]  i_load_data,
    input  logic                    i_load_last,
    output logic                    o_load_ready,
    output logic                    o_load_done,
    output logic                    o_load_error
);

    localparam int DEPTH  = 1 << ADDR_WIDTH;
    localparam int LEN_W  = ADDR_WIDTH + 1;
    localparam int BANK_W = (NUM_PROGRAMS > 1) ? $clog2(NUM_PROGRAMS) : 1;

    localparam logic [PSEL_WIDTH:0] NUM_PROGRAMS_L = (PSEL_WIDTH + 1)'(NUM_PROGRAMS);
    localparam logic [LEN_W-1:0]    DEPTH_L        = LEN_W'(DEPTH);

    typedef enum logic {
        S_IDLE,
        S_LOAD
    } load_state_t;

    // Storage and per-bank lengths
    logic [INSTR_WIDTH-1:0] r_mem [NUM_PROGRAMS][DEPTH];
    logic [LEN_W-1:0]       r_len [NUM_PROGRAMS];

    // Program select
    logic [PSEL_WIDTH-1:0]  r_active_program;
    logic                   r_select_none;
    logic [PSEL_WIDTH-1:0]  w_sel_idx;
    logic                   w_sel_none;
    logic [BANK_W-1:0]      w_active_idx;

    // Fetch
    logic [INSTR_WIDTH-1:0] r_instruction;
    logic                   r_instr_valid;
    logic [INSTR_WIDTH-1:0] w_read_data;
    logic                   w_past_len;
    logic                   w_loading_active;

    // Load FSM
    load_state_t            r_state;
    load_state_t            w_state_nxt;
    logic [BANK_W-1:0]      r_load_bank;
    logic [ADDR_WIDTH-1:0]  r_wp;
    logic                   r_load_done;
    logic                   r_load_error;
    logic                   w_bank_ok;
    logic                   w_start_ok;
    logic                   w_accept;
    logic                   w_load_ready;
    logic                   w_done_nxt;
    logic                   w_error_nxt;
    logic                   w_len_wr;
    logic [LEN_W-1:0]       w_len_val;

    // ------------------------------------------------------------------
    // Program select: lowest set switch wins; an all-zero latch keeps the
    // previous bank index and only raises select_none.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        w_sel_idx = '0;
        for (int i = NUM_PROGRAMS - 1; i >= 0; i--) begin
            if (i_program_select[i]) begin
                w_sel_idx = PSEL_WIDTH'(i);
            end
        end
    end

    assign w_sel_none = (i_program_select == '0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; this is what makes a same-cycle read see the old select.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_active_program <= '0;
            r_select_none    <= 1'b1;
        end else if (i_select_latch) begin
            r_select_none <= w_sel_none;
            if (!w_sel_none) begin
                r_active_program <= w_sel_idx;
            end
        end
    end

    assign w_active_idx = r_active_program[BANK_W-1:0];

    // ------------------------------------------------------------------
    // Load FSM
    // ------------------------------------------------------------------
    assign w_bank_ok = ({1'b0, i_load_bank} < NUM_PROGRAMS_L);

    always_comb begin
        w_state_nxt  = r_state;
        w_start_ok   = 1'b0;
        w_accept     = 1'b0;
        w_load_ready = 1'b0;
        w_done_nxt   = 1'b0;
        w_error_nxt  = 1'b0;
        w_len_wr     = 1'b0;
        w_len_val    = DEPTH_L;
        case (r_state)
            S_IDLE: begin
                if (i_load_start) begin
                    if (w_bank_ok) begin
                        w_start_ok  = 1'b1;
                        w_state_nxt = S_LOAD;
                    end else begin
                        w_error_nxt = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                w_load_ready = 1'b1;
                if (i_load_valid) begin
                    w_accept = 1'b1;
                    if (i_load_last) begin
                        w_len_wr    = 1'b1;
                        w_len_val   = {1'b0, r_wp} + LEN_W'(1);
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else if (r_wp == '1) begin
                        // Bank full without a last marker: keep it all, flag overflow.
                        w_len_wr    = 1'b1;
                        w_len_val   = DEPTH_L;
                        w_done_nxt  = 1'b1;
                        w_error_nxt = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_load_bank  <= '0;
            r_wp         <= '0;
            r_load_done  <= 1'b0;
            r_load_error <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_load_done  <= w_done_nxt;
            r_load_error <= w_error_nxt;
            if (w_start_ok) begin
                r_load_bank <= i_load_bank[BANK_W-1:0];
                r_wp        <= '0;
            end else if (w_accept) begin
                r_wp <= r_wp + ADDR_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int b = 0; b < NUM_PROGRAMS; b++) begin
                r_len[b] <= DEPTH_L;
            end
        end else if (w_len_wr) begin
            r_len[r_load_bank] <= w_len_val;
        end
    end

    // NOTE: the word array has no reset so it maps onto RAM; contents survive reset.
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_mem[r_load_bank][r_wp] <= i_load_data;
        end
    end

    // ------------------------------------------------------------------
    // Fetch: registered read; a bank being rewritten reads as HALT so the
    // CPU never executes a half-loaded program.
    // ------------------------------------------------------------------
    assign w_past_len       = ({1'b0, i_address} >= r_len[w_active_idx]);
    assign w_loading_active = (r_state == S_LOAD) && (r_load_bank == w_active_idx);

    always_comb begin
        w_read_data = r_mem[w_active_idx][i_address];
        if (r_select_none) begin
            w_read_data = '0;
        end else if (w_past_len || w_loading_active) begin
            w_read_data = HALT_INSTR;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_instruction <= '0;
            r_instr_valid <= 1'b0;
        end else begin
            r_instr_valid <= i_read_en;
            if (i_read_en) begin
                r_instruction <= w_read_data;
            end
        end
    end

    assign o_instruction    = r_instruction;
    assign o_instr_valid    = r_instr_valid;
    assign o_active_program = r_active_program;
    assign o_select_none    = r_select_none;
    assign o_load_ready     = w_load_ready;
    assign o_load_done      = r_load_done;
    assign o_load_error     = r_load_error;

endmodule

// File: tb/tb_program_bank_memory.sv
// Directed bench for program_bank_memory: reads are scored through an expected-data
// queue drained by an independent monitor; control outputs are checked in line.
module tb_program_bank_memory;

    localparam int          IW   = 16;
    localparam int          AW   = 7;
    localparam int          NP   = 8;
    localparam int          PW   = 4;
    localparam logic [15:0] HALT = 16'hE000;

    logic          clk;
    logic          reset;
    logic [NP-1:0] program_select;
    logic          select_latch;
    logic [AW-1:0] address;
    logic          read_en;
    logic [IW-1:0] instruction;
    logic          instr_valid;
    logic [PW-1:0] active_program;
    logic          select_none;
    logic          load_start;
    logic [PW-1:0] load_bank;
    logic          load_valid;
    logic [IW-1:0] load_data;
    logic          load_last;
    logic          load_ready;
    logic          load_done;
    logic          load_error;

    int            n_vec = 0;
    int            n_err = 0;
    logic [IW-1:0] exp_q[$];
    logic [IW-1:0] exp_word;
    logic [IW-1:0] beats[$];
    bit            mon_en = 0;

    program_bank_memory #(
        .INSTR_WIDTH (IW),
        .ADDR_WIDTH  (AW),
        .NUM_PROGRAMS(NP),
        .PSEL_WIDTH  (PW),
        .HALT_INSTR  (HALT)
    ) dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_program_select(program_select),
        .i_select_latch  (select_latch),
        .o_active_program(active_program),
        .o_select_none   (select_none),
        .i_address       (address),
        .i_read_en       (read_en),
        .o_instruction   (instruction),
        .o_instr_valid   (instr_valid),
        .i_load_start    (load_start),
        .i_load_bank     (load_bank),
        .i_load_valid    (load_valid),
        .i_load_data     (load_data),
        .i_load_last     (load_last),
        .o_load_ready    (load_ready),
        .o_load_done     (load_done),
        .o_load_error    (load_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [IW-1:0] e);
        address = a;
        read_en = 1'b1;
        exp_q.push_back(e);
        tick();
        read_en = 1'b0;
    endtask

    task automatic latch_sel(input logic [NP-1:0] s);
        program_select = s;
        select_latch   = 1'b1;
        tick();
        select_latch   = 1'b0;
    endtask

    // Streams the words in 'beats' into a bank, then checks the termination pulses.
    task automatic load_prog(input logic [PW-1:0] bank, input bit use_last, input bit exp_error);
        load_start = 1'b1;
        load_bank  = bank;
        tick();
        load_start = 1'b0;
        check("load_ready_in_load", load_ready, 1);
        for (int i = 0; i < beats.size(); i++) begin
            load_valid = 1'b1;
            load_data  = beats[i];
            load_last  = use_last && (i == beats.size() - 1);
            tick();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        check("load_done_pulse", load_done, 1);
        check("load_error_at_done", load_error, exp_error);
        check("load_ready_after", load_ready, 0);
        tick();
        check("load_done_cleared", load_done, 0);
    endtask

    // Monitor: every valid fetch must match the oldest expected word.
    always @(negedge clk) begin
        if (mon_en && instr_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_fetch: got %0h, expected no valid", instruction);
            end else begin
                exp_word = exp_q.pop_front();
                check("fetch_data", instruction, exp_word);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset          = 1'b1;
        program_select = '0;
        select_latch   = 1'b0;
        address        = '0;
        read_en        = 1'b0;
        load_start     = 1'b0;
        load_bank      = '0;
        load_valid     = 1'b0;
        load_data      = '0;
        load_last      = 1'b0;
        tick();
        tick();
        check("rst_instruction", instruction, 0);
        check("rst_instr_valid", instr_valid, 0);
        check("rst_active", active_program, 0);
        check("rst_select_none", select_none, 1);
        check("rst_load_ready", load_ready, 0);
        check("rst_load_done", load_done, 0);
        check("rst_load_error", load_error, 0);
        reset  = 1'b0;
        mon_en = 1;

        // 1: preload bank0, select it, fetch word 1
        beats = '{16'h1111, 16'h2222, 16'h3333};
        load_prog(4'd0, 1, 0);
        latch_sel(8'b0000_0001);
        check("t1_active", active_program, 0);
        check("t1_select_none", select_none, 0);
        do_read(7'd1, 16'h2222);
        tick();
        check("t1_valid_pulse", instr_valid, 0);
        check("t1_instr_hold", instruction, 16'h2222);
        do_read(7'd3, HALT);

        // 2: priority encode, then an empty latch
        latch_sel(8'b0001_0100);
        check("t2_active", active_program, 2);
        check("t2_select_none", select_none, 0);
        latch_sel(8'h00);
        check("t2_none_set", select_none, 1);
        check("t2_active_held", active_program, 2);
        do_read(7'd0, 16'h0000);

        // 3: load bank3; a same-cycle latch+read uses the old bank
        beats = '{16'h0105, 16'h4F11, 16'hE000};
        load_prog(4'd3, 1, 0);
        latch_sel(8'b0000_0001);
        program_select = 8'b1000_1000;
        select_latch   = 1'b1;
        address        = 7'd1;
        read_en        = 1'b1;
        exp_q.push_back(16'h2222);
        tick();
        select_latch = 1'b0;
        read_en      = 1'b0;
        check("t3_active", active_program, 3);
        do_read(7'd0, 16'h0105);
        do_read(7'd1, 16'h4F11);
        do_read(7'd2, 16'hE000);
        do_read(7'd3, HALT);

        // 4: out-of-range bank
        load_start = 1'b1;
        load_bank  = 4'd9;
        tick();
        load_start = 1'b0;
        check("t4_load_error", load_error, 1);
        check("t4_load_ready", load_ready, 0);
        check("t4_load_done", load_done, 0);
        tick();
        check("t4_error_cleared", load_error, 0);
        check("t4_ready_still0", load_ready, 0);

        // 5: overflow a bank with 128 beats and no last
        beats.delete();
        for (int i = 0; i < 128; i++) beats.push_back(16'h5000 + 16'(i));
        load_prog(4'd5, 0, 1);
        latch_sel(8'b0010_0000);
        check("t5_active", active_program, 5);
        do_read(7'd0, 16'h5000);
        do_read(7'd64, 16'h5040);
        do_read(7'd127, 16'h507F);
        beats = '{16'h1234, 16'h5678};
        load_prog(4'd5, 1, 0);
        do_read(7'd1, 16'h5678);
        do_read(7'd2, HALT);

        // 6: reset in the middle of a load on the active bank
        load_start = 1'b1;
        load_bank  = 4'd5;
        tick();
        load_start = 1'b0;
        check("t6_load_ready", load_ready, 1);
        do_read(7'd0, HALT);
        load_valid = 1'b1;
        load_data  = 16'hCCCC;
        tick();
        load_data  = 16'hDDDD;
        tick();
        load_valid = 1'b0;
        reset      = 1'b1;
        tick();
        check("t6_rst_ready", load_ready, 0);
        check("t6_rst_valid", instr_valid, 0);
        check("t6_rst_done", load_done, 0);
        check("t6_rst_error", load_error, 0);
        check("t6_rst_none", select_none, 1);
        check("t6_rst_instr", instruction, 0);
        reset = 1'b0;
        latch_sel(8'b0010_0000);
        do_read(7'd0, 16'hCCCC);
        do_read(7'd1, 16'hDDDD);
        do_read(7'd2, 16'h5002);
        do_read(7'd127, 16'h507F);

        tick();
        tick();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
